// File: rtl/perf_counter_ctrl_if.sv
// rtl/perf_counter_ctrl_if.sv - MMIO request/response bus into the performance counter bank.
interface perf_counter_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             mem_read;
  logic             mem_write;
  logic [3:0]       offset;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_resp;
  logic             busy;

  modport master (
    output mem_read, mem_write, offset,
    input  mem_rdata, mem_resp, busy
  );

  modport slave (
    input  mem_read, mem_write, offset,
    output mem_rdata, mem_resp, busy
  );
endinterface

// File: rtl/perf_counter_ctrl.sv
// rtl/perf_counter_ctrl.sv - saturating event counter bank with one-at-a-time read/clear FSM.
module perf_counter_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NUM_CTR = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count_en,
  input  logic [NUM_CTR-1:0] event_in,
  perf_counter_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT} state_t;

  state_t             state;
  logic [3:0]         idx;
  logic               op_rd;
  logic [NUM_CTR-1:0] clr;
  logic [WIDTH-1:0]   ctr [NUM_CTR];
  logic               req;

  assign req = bus.mem_read | bus.mem_write;

  // clr is registered on acceptance so the one-hot strobe lines up exactly with BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      op_rd         <= 1'b0;
      clr           <= '0;
      bus.mem_rdata <= '0;
      bus.mem_resp  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      clr          <= '0;
      bus.mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx      <= bus.offset;
            op_rd    <= bus.mem_read;
            if (!bus.mem_read) clr <= NUM_CTR'(1) << bus.offset;
            bus.busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (op_rd) bus.mem_rdata <= ctr[idx];
          bus.mem_resp <= 1'b1;
          state        <= RESP;
        end
        RESP: state <= WAIT;
        WAIT: begin
          if (!req) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear strobe wins over a same-cycle event; counters stick at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CTR; i++) begin
      if (rst || clr[i]) begin
        ctr[i] <= '0;
      end else if (count_en && event_in[i] && ctr[i] != CTR_MAX) begin
        ctr[i] <= ctr[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb/tb_perf_counter_ctrl.sv - scoreboard bench for perf_counter_ctrl against a cycle-count model.
module tb_perf_counter_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        count_en = 1'b0;
  logic [15:0] event_in = '0;

  perf_counter_ctrl_if #(.WIDTH(16)) bus ();

  perf_counter_ctrl #(.WIDTH(16), .NUM_CTR(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .event_in (event_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [16];
  logic [15:0] last_rd = '0;
  bit          clr_pend = 1'b0;
  logic [3:0]  clr_off = '0;
  int          cyc = 0;
  bit          acc_flag = 1'b0;
  bit          acc_rd = 1'b0;
  logic [3:0]  acc_off = '0;
  bit          ev_mode = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: each counter is a saturating tally of enabled events; a clear
  // zeroes it one cycle after acceptance; a read reports the tally as of acceptance.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      last_rd  = '0;
      clr_pend = 1'b0;
      q.delete();
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (clr_pend && i == int'(clr_off)) m[i] = '0;
        else if (count_en && event_in[i] && m[i] < 16'hFFFF) m[i] = m[i] + 16'd1;
      end
      clr_pend = 1'b0;
      if (acc_flag) begin
        if (acc_rd) begin
          last_rd = m[acc_off];
        end else begin
          clr_pend = 1'b1;
          clr_off  = acc_off;
        end
        q.push_back('{cyc, last_rd});
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst && bus.mem_resp) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 required=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_latency", 16'(cyc), 16'(e.cyc + 2));
        chk("resp_rdata", bus.mem_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (ev_mode) begin
      count_en = 1'b1;
      event_in = {1'b1, 15'($urandom)};
    end
  endtask

  // kind: 0 read, 1 clear, 2 read+write together
  task automatic do_txn(input int kind, input logic [3:0] off, input int hold,
                        output logic [15:0] got, output int acc_cyc);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk("idle_before_req", 16'(bus.busy), 16'd0);
    bus.mem_read  = (kind != 1);
    bus.mem_write = (kind != 0);
    bus.offset    = off;
    acc_rd        = (kind != 1);
    acc_off       = off;
    acc_flag      = 1'b1;
    acc_cyc       = cyc;
    tick();
    acc_flag   = 1'b0;
    bus.offset = 4'($urandom);
    n = 0;
    while (!bus.mem_resp && n < 10) begin
      tick();
      n++;
    end
    chk("resp_seen", 16'(bus.mem_resp), 16'd1);
    got = bus.mem_rdata;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("busy_while_held", 16'(bus.busy), 16'd1);
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int          ac;
    int          ac_clr;
    int          n;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.offset    = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_rdata", bus.mem_rdata, 16'd0);
    chk("reset_resp", 16'(bus.mem_resp), 16'd0);
    chk("reset_busy", 16'(bus.busy), 16'd0);
    for (int i = 0; i < 16; i++) begin
      do_txn(0, 4'(i), 0, got, ac);
      chk("reset_ctr_zero", got, 16'd0);
    end

    count_en = 1'b1;
    event_in = 16'h0008;
    repeat (5) tick();
    event_in = 16'h0000;
    do_txn(0, 4'd3, 0, got, ac);
    chk("ctr3_five", got, 16'h0005);
    do_txn(0, 4'd4, 0, got, ac);
    chk("ctr4_zero", got, 16'h0000);

    event_in = 16'h0080;
    repeat (3) tick();
    do_txn(1, 4'd7, 1, got, ac_clr);
    repeat (4) tick();
    do_txn(0, 4'd7, 0, got, ac);
    chk("clear_wins_event", got, 16'(ac - ac_clr - 1));
    event_in = 16'h0000;

    do_txn(0, 4'd3, 6, got, ac);
    chk("held_read_value", got, 16'h0005);
    chk("released_idle", 16'(bus.busy), 16'd0);
    do_txn(2, 4'd3, 0, got, ac);
    chk("both_is_read", got, 16'h0005);
    chk("next_accept_cycle", 16'(bus.busy), 16'd1);

    ev_mode = 1'b1;
    for (int k = 0; k < 40000 && m[15] < 16'hFFE0; k++) begin
      do_txn($urandom_range(0, 2), 4'($urandom_range(0, 14)), $urandom_range(0, 2), got, ac);
    end
    ev_mode  = 1'b0;
    event_in = 16'h8000;
    count_en = 1'b1;
    n = 0;
    while (m[15] != 16'hFFFE && n < 200) begin
      tick();
      n++;
    end
    event_in = 16'h0000;
    do_txn(0, 4'd15, 0, got, ac);
    chk("ctr15_preload", got, 16'hFFFE);
    event_in = 16'h8000;
    repeat (3) tick();
    event_in = 16'h0000;
    do_txn(0, 4'd15, 0, got, ac);
    chk("ctr15_saturated", got, 16'hFFFF);

    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    bus.mem_write = 1'b1;
    bus.offset    = 4'd2;
    acc_rd        = 1'b0;
    acc_off       = 4'd2;
    acc_flag      = 1'b1;
    tick();
    acc_flag = 1'b0;
    rst = 1'b1;
    bus.mem_write = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("abort_busy", 16'(bus.busy), 16'd0);
    chk("abort_rdata", bus.mem_rdata, 16'd0);
    chk("abort_resp", 16'(bus.mem_resp), 16'd0);
    count_en = 1'b0;
    event_in = 16'hFFFF;
    repeat (5) tick();
    for (int i = 0; i < 16; i++) begin
      do_txn(0, 4'(i), 0, got, ac);
      chk("frozen_ctr_zero", got, 16'd0);
    end
    event_in = 16'h0000;

    repeat (5) tick();
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
